// File: rtl/impl_deconv_if.sv
// Stream bundle for the implication-fold decoder.
// Input handshake carries fold words; output handshake carries decoded items.
interface impl_deconv_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] num;
  logic [W-1:0] known;
  logic         err;

  modport master (
    output in_valid,
    output in_out,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  num,
    input  known,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_out,
    input  out_ready,
    output in_ready,
    output out_valid,
    output num,
    output known,
    output err
  );
endinterface

// File: rtl/impl_deconv.sv
// Inverts the implication fold out = ~acc | num, one word per accept.
// A 1-deep output register drains in the same cycle it is refilled.
module impl_deconv #(
  parameter int COUNT_OF_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  impl_deconv_if.slave       bus,
  output logic               err_sticky,
  output logic [7:0]         count
);

  localparam int W = COUNT_OF_BITS;

  logic [W-1:0] r_acc;
  logic         r_out_valid;
  logic [W-1:0] r_num;
  logic [W-1:0] r_known;
  logic         r_err;
  logic         r_err_sticky;
  logic [7:0]   r_count;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_drain;
  logic [W-1:0] w_num;
  logic         w_err;

  // Handshake: room exists when empty or the held item leaves now.
  always_comb begin
    w_in_ready = (!r_out_valid || bus.out_ready) && !clear;
    w_accept   = bus.in_valid && w_in_ready;
    w_drain    = r_out_valid && bus.out_ready;
  end

  // Decode: bits where acc was 1 pass num through; acc 0 forces out 1.
  always_comb begin
    w_num = bus.in_out & r_acc;
    w_err = |(~r_acc & ~bus.in_out);
  end

  // Fold model and output register; clear outranks accept and drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '1;
      r_out_valid  <= 1'b0;
      r_num        <= '0;
      r_known      <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_count      <= 8'd0;
    end else if (clear) begin
      r_acc        <= '1;
      r_out_valid  <= 1'b0;
      r_num        <= '0;
      r_known      <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_count      <= 8'd0;
    end else if (w_accept) begin
      r_acc        <= bus.in_out;
      r_out_valid  <= 1'b1;
      r_num        <= w_num;
      r_known      <= r_acc;
      r_err        <= w_err;
      r_err_sticky <= r_err_sticky | w_err;
      r_count      <= r_count + 8'd1;
    end else if (w_drain) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Drive the bundle and status ports from registered state.
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = r_out_valid;
    bus.num       = r_num;
    bus.known     = r_known;
    bus.err       = r_err;
    err_sticky    = r_err_sticky;
    count         = r_count;
  end

endmodule

// File: tb/tb_impl_deconv.sv
// Directed and random stimulus for impl_deconv against a per-bit model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_impl_deconv;

  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       err_sticky;
  logic [7:0] count;

  impl_deconv_if #(.W(W)) bus ();

  impl_deconv #(.COUNT_OF_BITS(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus.slave),
    .err_sticky (err_sticky),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference state: what a decoder reading the fold must remember
  logic [W-1:0] m_acc;
  bit           m_full;
  logic [W-1:0] m_num;
  logic [W-1:0] m_known;
  bit           m_err;
  bit           m_sticky;
  int           m_items;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc    = '1;
    m_full   = 0;
    m_num    = '0;
    m_known  = '0;
    m_err    = 0;
    m_sticky = 0;
    m_items  = 0;
  endtask

  // Bit-by-bit inversion of out = ~acc | num.
  task automatic decode(input logic [W-1:0] acc, input logic [W-1:0] x,
                        output logic [W-1:0] n, output logic [W-1:0] k,
                        output bit e);
    n = '0;
    k = '0;
    e = 0;
    for (int b = 0; b < W; b++) begin
      if (acc[b]) begin
        k[b] = 1'b1;
        n[b] = x[b];
      end else if (!x[b]) begin
        e = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_full));
    chk({tag, ".count"}, 32'(count), 32'(m_items % 256));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    if (m_full) begin
      chk({tag, ".num"}, 32'(bus.num), 32'(m_num));
      chk({tag, ".known"}, 32'(bus.known), 32'(m_known));
      chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs.
  task automatic cycle(input string tag, input bit iv,
                       input logic [W-1:0] io, input bit ordy,
                       input bit clr);
    bit rdy;
    bit take;
    logic [W-1:0] n;
    logic [W-1:0] k;
    bit e;
    bus.in_valid  = iv;
    bus.in_out    = io;
    bus.out_ready = ordy;
    clear         = clr;
    rdy  = (!m_full || ordy) && !clr;
    take = iv && rdy;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (take) begin
      decode(m_acc, io, n, k, e);
      m_num    = n;
      m_known  = k;
      m_err    = e;
      m_sticky = m_sticky || e;
      m_acc    = io;
      m_full   = 1;
      m_items  = m_items + 1;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] snap_num;
    logic [W-1:0] snap_known;
    bit           saw_bubble;

    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_out    = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset state
    #12;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.err_sticky", 32'(err_sticky), 32'd0);
    chk("rst.known", 32'(bus.known), 32'd0);

    @(negedge clk);
    rst = 1'b1;

    // first item after release: acc is all ones, everything known
    cycle("a1", 1, 4'b1010, 1, 0);
    chk("a1.num_k", 32'(bus.num), 32'hA);
    chk("a1.known_k", 32'(bus.known), 32'hF);
    chk("a1.count_k", 32'(count), 32'd1);
    cycle("a2", 1, 4'b1101, 1, 0);
    chk("a2.num_k", 32'(bus.num), 32'h8);
    chk("a2.known_k", 32'(bus.known), 32'hA);
    chk("a2.err_k", 32'(bus.err), 32'd0);
    cycle("a3", 1, 4'b0000, 1, 0);
    chk("a3.num_k", 32'(bus.num), 32'h0);
    chk("a3.known_k", 32'(bus.known), 32'hD);
    chk("a3.err_k", 32'(bus.err), 32'd1);
    chk("a3.sticky_k", 32'(err_sticky), 32'd1);

    // backpressure: outputs frozen, no accept
    snap_num   = bus.num;
    snap_known = bus.known;
    for (int i = 0; i < 4; i++) begin
      cycle("stall", 1, 4'b0101, 0, 0);
      chk("stall.ready_k", 32'(bus.in_ready), 32'd0);
      chk("stall.num_frz", 32'(bus.num), 32'(snap_num));
      chk("stall.known_frz", 32'(bus.known), 32'(snap_known));
    end
    cycle("unstall", 1, 4'b0101, 1, 0);
    chk("unstall.count_k", 32'(count), 32'd4);

    // clear beats a valid input
    cycle("clr", 1, 4'b1111, 1, 1);
    chk("clr.out_valid_k", 32'(bus.out_valid), 32'd0);
    chk("clr.count_k", 32'(count), 32'd0);
    chk("clr.sticky_k", 32'(err_sticky), 32'd0);
    cycle("post_clr", 1, 4'b0110, 1, 0);
    chk("post_clr.known_k", 32'(bus.known), 32'hF);
    chk("post_clr.num_k", 32'(bus.num), 32'h6);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", bit'($urandom_range(0, 3) != 0),
            W'($urandom), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 39) == 0));
    end

    // 256 back-to-back accepts wrap the counter
    cycle("wrap_clr", 0, 4'b0000, 1, 1);
    saw_bubble = 0;
    for (int i = 0; i < 256; i++) begin
      cycle("wrap", 1, W'($urandom), 1, 0);
      if (!bus.out_valid) saw_bubble = 1;
    end
    chk("wrap.count_k", 32'(count), 32'd0);
    chk("wrap.no_bubble", 32'(saw_bubble), 32'd0);

    // async reset while an item is held
    cycle("ar1", 1, 4'b0000, 1, 0);
    cycle("ar2", 1, 4'b0000, 1, 0);
    cycle("ar_hold", 0, 4'b0000, 0, 0);
    chk("ar.sticky_pre", 32'(err_sticky), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.out_valid_k", 32'(bus.out_valid), 32'd0);
    chk("ar.count_k", 32'(count), 32'd0);
    chk("ar.sticky_k", 32'(err_sticky), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle("ar_rel", 1, 4'b0011, 0, 0);
    chk("ar_rel.known_k", 32'(bus.known), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
